ray_caster_tiled: RTL and testbench



---
 rtl/ray_pkg.sv | 34 +++
 rtl/ray_out_fifo.sv | 78 +++++++
 rtl/ray_caster_tiled.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_ray_caster_tiled.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_pkg.sv
// Shared types for the tiled primary-ray caster: vector layout, FSM states, pipeline depth.
package ray_pkg;

  // Default component width; vectors pack x in the low slice, then y, z on top.
  localparam int unsigned CW_DEF   = 32;
  // Register stages between pixel issue and the output FIFO write.
  localparam int unsigned PIPE_LAT = 4;

  typedef logic [CW_DEF-1:0]   comp_t;
  typedef logic [3*CW_DEF-1:0] vec_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCast  = 2'd1,
    StDrain = 2'd2
  } state_e;

  function automatic comp_t vec_x(input vec_t v);
    return v[CW_DEF-1:0];
  endfunction

  function automatic comp_t vec_y(input vec_t v);
    return v[2*CW_DEF-1:CW_DEF];
  endfunction

  function automatic comp_t vec_z(input vec_t v);
    return v[3*CW_DEF-1:2*CW_DEF];
  endfunction

  function automatic vec_t vec_pack(input comp_t x, input comp_t y, input comp_t z);
    return {z, y, x};
  endfunction

endpackage

// File: rtl/ray_out_fifo.sv
// First-word-fall-through FIFO with occupancy count and synchronous flush.
// The head entry is visible on rdata_o whenever valid_o is high.
module ray_out_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             flush_i,
  input  logic             wr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             rd_i,
  output logic [Width-1:0] rdata_o,
  output logic             valid_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_wr, do_rd;

  assign do_rd = rd_i && (cnt_q != '0);
  // A write into a full FIFO is dropped unless a read frees a slot the same cycle.
  assign do_wr = wr_i && ((cnt_q != CntW'(Depth)) || do_rd);

  // Next-state for pointers, count and storage.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (en_i) begin
      if (flush_i) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        cnt_d    = '0;
      end else begin
        if (do_wr) begin
          mem_d[wr_ptr_q] = wdata_i;
          wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
          rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        cnt_d = cnt_q + CntW'(do_wr) - CntW'(do_rd);
      end
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; entries are only observed when counted valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign valid_o = (cnt_q != '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/ray_caster_tiled.sv
// Tiled primary-ray generator: walks the frame tile by tile, computes one camera ray per
// pixel through a 4-stage pipeline and buffers results in an output FIFO with backpressure.
// Optional build macro RAY_CASTER_TILED_STATS_EN adds transfer/stall counters.
module ray_caster_tiled
  import ray_pkg::*;
#(
  parameter int unsigned CW         = 32,
  parameter int unsigned MAX_RES_X  = 640,
  parameter int unsigned MAX_RES_Y  = 480,
  parameter int unsigned TILE_W     = 8,
  parameter int unsigned TILE_H     = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  output logic            ready,
  input  logic            render_start,
  input  logic            abort,
  input  logic [10:0]     res_x,
  input  logic [10:0]     res_y,
  input  logic [3*CW-1:0] camera_origin,
  input  logic [3*CW-1:0] camera_front,
  input  logic [3*CW-1:0] camera_left,
  input  logic [3*CW-1:0] camera_up,
  output logic [10:0]     out_x,
  output logic [10:0]     out_y,
  output logic [3*CW-1:0] out_origin,
  output logic [3*CW-1:0] out_direction,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            frame_done,
  output logic            busy
`ifdef RAY_CASTER_TILED_STATS_EN
  ,
  output logic [31:0]     stat_rays,
  output logic [31:0]     stat_stall
`endif
);

  localparam int unsigned VW   = 3 * CW;
  localparam int unsigned FW   = 22 + VW;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LatW = $clog2(PIPE_LAT + 1);

  // Per-component CW-bit wrapping product with a signed 12-bit offset.
  function automatic logic [CW-1:0] mul_c(input logic [CW-1:0] a, input logic [11:0] o);
    logic [CW-1:0] oe;
    oe = CW'($signed(o));
    return a * oe;
  endfunction

  function automatic logic [VW-1:0] vmul(input logic [VW-1:0] v, input logic [11:0] o);
    return {mul_c(v[3*CW-1:2*CW], o), mul_c(v[2*CW-1:CW], o), mul_c(v[CW-1:0], o)};
  endfunction

  function automatic logic [VW-1:0] vadd(input logic [VW-1:0] a, input logic [VW-1:0] b);
    return {a[3*CW-1:2*CW] + b[3*CW-1:2*CW], a[2*CW-1:CW] + b[2*CW-1:CW],
            a[CW-1:0] + b[CW-1:0]};
  endfunction

  state_e          state_q, state_d;
  logic [10:0]     res_x_q, res_x_d, res_y_q, res_y_d;
  logic [VW-1:0]   org_q, org_d, front_q, front_d, left_q, left_d, up_q, up_d;
  logic [10:0]     x_q, x_d, y_q, y_d, tx_q, tx_d, ty_q, ty_d;
  logic            frame_done_q, frame_done_d;

  logic            s1_v_q, s1_v_d, s2_v_q, s2_v_d, s3_v_q, s3_v_d, s4_v_q, s4_v_d;
  logic [21:0]     s1_xy_q, s1_xy_d, s2_xy_q, s2_xy_d, s3_xy_q, s3_xy_d, s4_xy_q, s4_xy_d;
  logic [11:0]     s1_ox_q, s1_ox_d, s1_oy_q, s1_oy_d;
  logic [VW-1:0]   s2_pl_q, s2_pl_d, s2_pu_q, s2_pu_d, s3_sum_q, s3_sum_d, s4_dir_q, s4_dir_d;

  logic [10:0]     res_x_in, res_y_in;
  logic [11:0]     tx_next, ty_next;
  logic            last_tx, last_ty;
  logic [10:0]     x_end, y_end;
  logic [LatW-1:0] inflight;
  logic [CntW-1:0] fifo_cnt;
  logic            fifo_valid, can_issue, transfer, start_ok;
  logic [FW-1:0]   fifo_head;

  assign res_x_in = (res_x > 11'(MAX_RES_X)) ? 11'(MAX_RES_X) : res_x;
  assign res_y_in = (res_y > 11'(MAX_RES_Y)) ? 11'(MAX_RES_Y) : res_y;

  // Current tile extents, clipped against the latched resolution.
  assign tx_next = {1'b0, tx_q} + 12'(TILE_W);
  assign ty_next = {1'b0, ty_q} + 12'(TILE_H);
  assign last_tx = tx_next >= {1'b0, res_x_q};
  assign last_ty = ty_next >= {1'b0, res_y_q};
  assign x_end   = last_tx ? (res_x_q - 11'd1) : (tx_next[10:0] - 11'd1);
  assign y_end   = last_ty ? (res_y_q - 11'd1) : (ty_next[10:0] - 11'd1);

  assign inflight  = LatW'(s1_v_q) + LatW'(s2_v_q) + LatW'(s3_v_q) + LatW'(s4_v_q);
  // Counting in-flight work reserves a FIFO slot for every issued pixel.
  assign can_issue = (32'(fifo_cnt) + 32'(inflight)) < FIFO_DEPTH;
  assign transfer  = ce && fifo_valid && out_ready;
  assign start_ok  = ce && (state_q == StIdle) && render_start && !abort;

  // Traversal FSM, camera latch and pipeline advance.
  always_comb begin
    state_d      = state_q;
    res_x_d      = res_x_q;
    res_y_d      = res_y_q;
    org_d        = org_q;
    front_d      = front_q;
    left_d       = left_q;
    up_d         = up_q;
    x_d          = x_q;
    y_d          = y_q;
    tx_d         = tx_q;
    ty_d         = ty_q;
    frame_done_d = frame_done_q;
    s1_v_d = s1_v_q;  s1_xy_d = s1_xy_q;  s1_ox_d = s1_ox_q;  s1_oy_d = s1_oy_q;
    s2_v_d = s2_v_q;  s2_xy_d = s2_xy_q;  s2_pl_d = s2_pl_q;  s2_pu_d = s2_pu_q;
    s3_v_d = s3_v_q;  s3_xy_d = s3_xy_q;  s3_sum_d = s3_sum_q;
    s4_v_d = s4_v_q;  s4_xy_d = s4_xy_q;  s4_dir_d = s4_dir_q;

    if (ce) begin
      frame_done_d = 1'b0;
      s1_v_d   = 1'b0;
      s1_xy_d  = {x_q, y_q};
      s1_ox_d  = {2'b00, res_x_q[10:1]} - {1'b0, x_q} - 12'd1;
      s1_oy_d  = {2'b00, res_y_q[10:1]} - {1'b0, y_q} - 12'd1;
      s2_v_d   = s1_v_q;
      s2_xy_d  = s1_xy_q;
      s2_pl_d  = vmul(left_q, s1_ox_q);
      s2_pu_d  = vmul(up_q, s1_oy_q);
      s3_v_d   = s2_v_q;
      s3_xy_d  = s2_xy_q;
      s3_sum_d = vadd(s2_pl_q, s2_pu_q);
      s4_v_d   = s3_v_q;
      s4_xy_d  = s3_xy_q;
      s4_dir_d = vadd(s3_sum_q, front_q);

      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            res_x_d = res_x_in;
            res_y_d = res_y_in;
            org_d   = camera_origin;
            front_d = camera_front;
            left_d  = camera_left;
            up_d    = camera_up;
            if ((res_x_in == '0) || (res_y_in == '0)) begin
              frame_done_d = 1'b1;
            end else begin
              state_d = StCast;
              x_d  = '0;
              y_d  = '0;
              tx_d = '0;
              ty_d = '0;
            end
          end
        end
        StCast: begin
          if (can_issue) begin
            s1_v_d = 1'b1;
            if (x_q != x_end) begin
              x_d = x_q + 11'd1;
            end else if (y_q != y_end) begin
              x_d = tx_q;
              y_d = y_q + 11'd1;
            end else if (!last_tx) begin
              tx_d = tx_next[10:0];
              x_d  = tx_next[10:0];
              y_d  = ty_q;
            end else if (!last_ty) begin
              tx_d = '0;
              x_d  = '0;
              ty_d = ty_next[10:0];
              y_d  = ty_next[10:0];
            end else begin
              state_d = StDrain;
            end
          end
        end
        StDrain: begin
          // The last ray leaves the FIFO this cycle with nothing behind it.
          if (transfer && (fifo_cnt == CntW'(1)) && (inflight == '0)) begin
            frame_done_d = 1'b1;
            state_d      = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase

      if (abort && (state_q != StIdle)) begin
        state_d      = StIdle;
        frame_done_d = 1'b0;
        s1_v_d       = 1'b0;
        s2_v_d       = 1'b0;
        s3_v_d       = 1'b0;
        s4_v_d       = 1'b0;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      res_x_q <= '0;  res_y_q <= '0;
      org_q   <= '0;  front_q <= '0;  left_q <= '0;  up_q <= '0;
      x_q     <= '0;  y_q     <= '0;  tx_q   <= '0;  ty_q <= '0;
      frame_done_q <= 1'b0;
      s1_v_q <= 1'b0;  s1_xy_q <= '0;  s1_ox_q <= '0;  s1_oy_q <= '0;
      s2_v_q <= 1'b0;  s2_xy_q <= '0;  s2_pl_q <= '0;  s2_pu_q <= '0;
      s3_v_q <= 1'b0;  s3_xy_q <= '0;  s3_sum_q <= '0;
      s4_v_q <= 1'b0;  s4_xy_q <= '0;  s4_dir_q <= '0;
    end else begin
      state_q <= state_d;
      res_x_q <= res_x_d;  res_y_q <= res_y_d;
      org_q   <= org_d;    front_q <= front_d;  left_q <= left_d;  up_q <= up_d;
      x_q     <= x_d;      y_q     <= y_d;      tx_q   <= tx_d;    ty_q <= ty_d;
      frame_done_q <= frame_done_d;
      s1_v_q <= s1_v_d;  s1_xy_q <= s1_xy_d;  s1_ox_q <= s1_ox_d;  s1_oy_q <= s1_oy_d;
      s2_v_q <= s2_v_d;  s2_xy_q <= s2_xy_d;  s2_pl_q <= s2_pl_d;  s2_pu_q <= s2_pu_d;
      s3_v_q <= s3_v_d;  s3_xy_q <= s3_xy_d;  s3_sum_q <= s3_sum_d;
      s4_v_q <= s4_v_d;  s4_xy_q <= s4_xy_d;  s4_dir_q <= s4_dir_d;
    end
  end

  ray_out_fifo #(
    .Width(FW),
    .Depth(FIFO_DEPTH),
    .CntW (CntW)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (ce),
    .flush_i(abort && (state_q != StIdle)),
    .wr_i   (s4_v_q),
    .wdata_i({s4_xy_q, s4_dir_q}),
    .rd_i   (out_ready),
    .rdata_o(fifo_head),
    .valid_o(fifo_valid),
    .count_o(fifo_cnt)
  );

  // Payload is zeroed when no ray is presented so idle outputs read as zero.
  assign out_valid     = fifo_valid;
  assign out_x         = fifo_valid ? fifo_head[FW-1 -: 11] : '0;
  assign out_y         = fifo_valid ? fifo_head[FW-12 -: 11] : '0;
  assign out_direction = fifo_valid ? fifo_head[VW-1:0] : '0;
  assign out_origin    = fifo_valid ? org_q : '0;
  assign frame_done    = frame_done_q;
  assign ready         = (state_q == StIdle);
  assign busy          = (state_q != StIdle);

`ifdef RAY_CASTER_TILED_STATS_EN
  logic [31:0] stat_rays_q, stat_rays_d, stat_stall_q, stat_stall_d;

  // Saturating transfer and stall counters, cleared by an accepted start.
  always_comb begin
    stat_rays_d  = stat_rays_q;
    stat_stall_d = stat_stall_q;
    if (start_ok) begin
      stat_rays_d  = '0;
      stat_stall_d = '0;
    end else begin
      if (transfer && (stat_rays_q != '1)) begin
        stat_rays_d = stat_rays_q + 32'd1;
      end
      if (ce && fifo_valid && !out_ready && (stat_stall_q != '1)) begin
        stat_stall_d = stat_stall_q + 32'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_rays_q  <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_rays_q  <= stat_rays_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_rays  = stat_rays_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_ray_caster_tiled.sv
// Scoreboard bench for ray_caster_tiled: stimulus pushes expected rays, a negedge monitor
// pops and compares on every transfer.
module tb_ray_caster_tiled;
  import ray_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, ce, ready, render_start, abort, out_valid, out_ready, frame_done, busy;
  logic [10:0] res_x, res_y, out_x, out_y;
  logic [95:0] camera_origin, camera_front, camera_left, camera_up, out_origin, out_direction;
`ifdef RAY_CASTER_TILED_STATS_EN
  logic [31:0] stat_rays, stat_stall;
`endif

  always #5 clk = ~clk;

  ray_caster_tiled u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ce           (ce),
    .ready        (ready),
    .render_start (render_start),
    .abort        (abort),
    .res_x        (res_x),
    .res_y        (res_y),
    .camera_origin(camera_origin),
    .camera_front (camera_front),
    .camera_left  (camera_left),
    .camera_up    (camera_up),
    .out_x        (out_x),
    .out_y        (out_y),
    .out_origin   (out_origin),
    .out_direction(out_direction),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .frame_done   (frame_done),
    .busy         (busy)
`ifdef RAY_CASTER_TILED_STATS_EN
    ,
    .stat_rays    (stat_rays),
    .stat_stall   (stat_stall)
`endif
  );

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [95:0] dir;
    logic [95:0] org;
  } exp_t;

  exp_t        exp_q[$];
  logic [21:0] rx_log[$];
  int checks = 0, errors = 0, cyc = 0;
  int xfer_cnt = 0, done_cnt = 0, done_cyc = -1, last_xfer_cyc = -1, first_valid_cyc = -1;
  int stall_cnt = 0, done_base = 0, start_cyc = 0;
  logic [95:0] first_dir;
  logic        stall_prev = 1'b0;
  exp_t        stall_pl;
  bit          rnd_on = 1'b0;

  localparam logic [95:0] ORG   = 96'h00000007_00000006_00000005;
  localparam logic [95:0] FRONT = 96'h00000001_00000000_00000000;
  localparam logic [95:0] LEFT  = 96'h00000000_00000000_00000001;
  localparam logic [95:0] UP    = 96'h00000000_00000001_00000000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mcomp(input logic [31:0] l, input logic [31:0] u,
                                        input logic [31:0] f, input int ox, input int oy);
    return l * 32'(ox) + u * 32'(oy) + f;
  endfunction

  // Reference traversal: tiles in raster order, pixels raster-ordered inside each tile.
  task automatic push_frame(input int rx, input int ry, input logic [95:0] org,
                            input logic [95:0] fr, input logic [95:0] le, input logic [95:0] up);
    int cx, cy, ox, oy;
    exp_t e;
    cx = (rx > 640) ? 640 : rx;
    cy = (ry > 480) ? 480 : ry;
    for (int ty = 0; ty < cy; ty += 8)
      for (int tx = 0; tx < cx; tx += 8)
        for (int y = ty; y < ty + 8 && y < cy; y++)
          for (int x = tx; x < tx + 8 && x < cx; x++) begin
            ox = cx / 2 - x - 1;
            oy = cy / 2 - y - 1;
            e.x   = 11'(x);
            e.y   = 11'(y);
            e.org = org;
            e.dir = vec_pack(mcomp(vec_x(le), vec_x(up), vec_x(fr), ox, oy),
                             mcomp(vec_y(le), vec_y(up), vec_y(fr), ox, oy),
                             mcomp(vec_z(le), vec_z(up), vec_z(fr), ox, oy));
            exp_q.push_back(e);
          end
  endtask

  task automatic start(input int rx, input int ry, input logic [95:0] org,
                       input logic [95:0] fr, input logic [95:0] le, input logic [95:0] up);
    @(posedge clk); #1;
    xfer_cnt = 0; rx_log.delete(); first_valid_cyc = -1; stall_cnt = 0; done_base = done_cnt;
    push_frame(rx, ry, org, fr, le, up);
    res_x = 11'(rx); res_y = 11'(ry);
    camera_origin = org; camera_front = fr; camera_left = le; camera_up = up;
    render_start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    render_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done_cnt == done_base && n < budget) begin
      @(posedge clk); n++;
    end
    chk({name, "_done"}, 256'(done_cnt - done_base), 256'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_xfer(input int target, input int budget, input string name);
    int n = 0;
    while (xfer_cnt < target && n < budget) begin
      @(posedge clk); n++;
    end
    chk({name, "_reach"}, 256'(xfer_cnt >= target), 256'd1);
  endtask

  // Monitor: transfers, stall stability, frame_done timing.
  always @(negedge clk) begin
    exp_t cur, e;
    cur = {out_x, out_y, out_direction, out_origin};
    if (rst_n) begin
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (stall_prev && out_valid) chk("stall_stable", cur, stall_pl);
      if (ce && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ray", cur, '0);
        end else begin
          e = exp_q.pop_front();
          chk("ray", cur, e);
        end
        if (xfer_cnt == 0) first_dir = out_direction;
        rx_log.push_back({out_x, out_y});
        xfer_cnt++;
        last_xfer_cyc = cyc;
      end
      if (ce && out_valid && !out_ready) stall_cnt++;
      stall_prev = ce && out_valid && !out_ready;
      stall_pl   = cur;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] snap;
    rst_n = 1'b0; ce = 1'b1; render_start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    res_x = '0; res_y = '0;
    camera_origin = '0; camera_front = '0; camera_left = '0; camera_up = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1); chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0); chk("rst_done", frame_done, 0);
    chk("rst_payload", {out_x, out_y, out_origin, out_direction}, 0);
    rst_n = 1'b1;

    // 16x16 frame, unit camera basis.
    start(16, 16, ORG, FRONT, LEFT, UP);
    chk("cast_busy", busy, 1);
    wait_xfer(20, 200, "f1_20");
    // Mid-frame start and camera changes must not disturb the frame.
    @(posedge clk); #1;
    res_x = 11'd4; res_y = 11'd4; camera_left = UP; camera_front = ORG; render_start = 1'b1;
    @(posedge clk); #1;
    render_start = 1'b0;
    chk("ignore_start_busy", busy, 1);
    wait_xfer(50, 200, "f1_50");
    @(posedge clk); #1;
    ce = 1'b0;
    @(negedge clk);
    snap = {out_valid, out_x, out_y, out_direction, out_origin, busy, ready, frame_done};
    chk("ce_snap_valid", out_valid, 1);
    repeat (9) begin
      @(negedge clk);
      chk("ce_freeze", {out_valid, out_x, out_y, out_direction, out_origin, busy, ready,
                        frame_done}, snap);
    end
    @(posedge clk); #1;
    ce = 1'b1;
    wait_done(2000, "f1");
    // Issue in the cycle after start, first ray visible 5 cycles after issue.
    chk("f1_latency", 256'(first_valid_cyc - start_cyc), 256'd6);
    chk("f1_first_dir", first_dir, vec_pack(32'd7, 32'd7, 32'd1));
    chk("f1_count", 256'(rx_log.size()), 256'd256);
    chk("f1_ray0", rx_log[0], {11'd0, 11'd0});
    chk("f1_ray9", rx_log[8], {11'd0, 11'd1});
    chk("f1_ray65", rx_log[64], {11'd8, 11'd0});
    chk("f1_done_align", 256'(done_cyc - last_xfer_cyc), 256'd1);
    chk("f1_queue_empty", 256'(exp_q.size()), 256'd0);
    chk("f1_ready", ready, 1);

    // Clipped 10x3 frame.
    start(10, 3, ORG, FRONT, LEFT, UP);
    wait_done(500, "f2");
    chk("f2_count", 256'(rx_log.size()), 256'd30);
    chk("f2_clip_first", rx_log[24], {11'd8, 11'd0});
    chk("f2_clip_last", rx_log[29], {11'd9, 11'd2});
    chk("f2_queue_empty", 256'(exp_q.size()), 256'd0);

    // Zero width: immediate frame_done, no rays.
    start(0, 5, ORG, FRONT, LEFT, UP);
    repeat (10) @(posedge clk);
    #1;
    chk("zero_done_cnt", 256'(done_cnt - done_base), 256'd1);
    chk("zero_done_cyc", 256'(done_cyc - start_cyc), 256'd1);
    chk("zero_rays", 256'(xfer_cnt), 256'd0);
    chk("zero_ready", ready, 1);

    // Abort together with start in IDLE: nothing happens.
    @(posedge clk); #1;
    done_base = done_cnt; xfer_cnt = 0;
    res_x = 11'd16; res_y = 11'd16; abort = 1'b1; render_start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; render_start = 1'b0;
    chk("abort_start_ready", ready, 1);
    repeat (12) @(posedge clk);
    #1;
    chk("abort_start_nodone", 256'(done_cnt - done_base), 256'd0);
    chk("abort_start_norays", 256'(xfer_cnt), 256'd0);

    // 64x64 with random backpressure.
    rnd_on = 1'b1;
    fork
      while (rnd_on) begin
        @(posedge clk); #1;
        if (rnd_on) out_ready = ($urandom_range(0, 99) < 30);
      end
    join_none
    start(64, 64, ORG, FRONT, LEFT, UP);
    wait_done(40000, "f5");
    rnd_on = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b1;
    chk("f5_count", 256'(rx_log.size()), 256'd4096);
    chk("f5_queue_empty", 256'(exp_q.size()), 256'd0);
`ifdef RAY_CASTER_TILED_STATS_EN
    chk("f5_stat_rays", stat_rays, 256'd4096);
    chk("f5_stat_stall", stat_stall, 256'(stall_cnt));
`endif

    // Abort around ray 100 with the FIFO full.
    start(64, 64, ORG, FRONT, LEFT, UP);
    wait_xfer(100, 500, "f6_100");
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("abort_pre_valid", out_valid, 1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_valid", out_valid, 0);
    chk("abort_ready", ready, 1);
    chk("abort_busy", busy, 0);
    repeat (20) @(posedge clk);
    #1;
    out_ready = 1'b1;
    chk("abort_nodone", 256'(done_cnt - done_base), 256'd0);

    // Fresh frame after abort starts from (0,0).
    start(16, 16, ORG, FRONT, LEFT, UP);
    wait_done(2000, "f7");
    chk("f7_count", 256'(rx_log.size()), 256'd256);
    chk("f7_ray0", rx_log[0], {11'd0, 11'd0});
    chk("f7_queue_empty", 256'(exp_q.size()), 256'd0);

    // Component wrap: (2^31-1) * 2 truncated to 32 bits.
    start(6, 1, ORG, 96'd0, vec_pack(32'h7FFF_FFFF, 32'd0, 32'd0), 96'd0);
    wait_done(500, "f8");
    chk("wrap_dir", first_dir, vec_pack(32'hFFFF_FFFE, 32'd0, 32'd0));
    chk("f8_count", 256'(rx_log.size()), 256'd6);
`ifdef RAY_CASTER_TILED_STATS_EN
    chk("f8_stat_rays", stat_rays, 256'(xfer_cnt));
    chk("f8_stat_stall", stat_stall, 256'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
